// File: rtl/pong_pkg.sv
// Shared pong datapath definitions: seven-segment encodings, score FSM states,
// winner codes and a saturating two-digit BCD increment.
package pong_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } score_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Saturates at 99: a point scored at 99 is dropped.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 produce an all-off pattern.
module bcd_seg_decode
  import pong_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper with win detection and frame-latched segment outputs.
// Optional macro SCORE_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [6:0] seg_p1_tens,
  output logic [6:0] seg_p1_ones,
  output logic [6:0] seg_p2_tens,
  output logic [6:0] seg_p2_ones,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam bcd2_t WIN_BCD = '{tens: 4'(WIN_SCORE / 10), ones: 4'(WIN_SCORE % 10)};

`ifdef SCORE_BLANK_LEADING_ZERO_EN
  localparam logic [6:0] TENS_RST = SEG_BLANK;
`else
  localparam logic [6:0] TENS_RST = SEG_0;
`endif

  score_state_t state;
  bcd2_t        p1_score, p2_score;
  bcd2_t        p1_next, p2_next;
  logic         p1_hit, p2_hit;

  always_comb begin
    p1_next = point_p1 ? bcd_inc(p1_score) : p1_score;
    p2_next = point_p2 ? bcd_inc(p2_score) : p2_score;
    p1_hit  = (p1_next == WIN_BCD);
    p2_hit  = (p2_next == WIN_BCD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      p1_score  <= '0;
      p2_score  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else if (new_game) begin
      state     <= PLAY;
      p1_score  <= '0;
      p2_score  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      case (state)
        PLAY: begin
          p1_score <= p1_next;
          p2_score <= p2_next;
          if (p1_hit || p2_hit) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= {p2_hit, p1_hit};
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: state <= PLAY;
      endcase
    end
  end

  logic [6:0] dec_p1_tens, dec_p1_ones, dec_p2_tens, dec_p2_ones;
  logic [6:0] pat_p1_tens, pat_p2_tens;

  bcd_seg_decode u_dec_p1_tens (.digit(p1_score.tens), .seg(dec_p1_tens));
  bcd_seg_decode u_dec_p1_ones (.digit(p1_score.ones), .seg(dec_p1_ones));
  bcd_seg_decode u_dec_p2_tens (.digit(p2_score.tens), .seg(dec_p2_tens));
  bcd_seg_decode u_dec_p2_ones (.digit(p2_score.ones), .seg(dec_p2_ones));

  always_comb begin
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    pat_p1_tens = (p1_score.tens == 4'd0) ? SEG_BLANK : dec_p1_tens;
    pat_p2_tens = (p2_score.tens == 4'd0) ? SEG_BLANK : dec_p2_tens;
`else
    pat_p1_tens = dec_p1_tens;
    pat_p2_tens = dec_p2_tens;
`endif
  end

  // Shadow registers sample the pre-increment score so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1_tens <= TENS_RST;
      seg_p1_ones <= SEG_0;
      seg_p2_tens <= TENS_RST;
      seg_p2_ones <= SEG_0;
    end else if (frame_tick) begin
      seg_p1_tens <= pat_p1_tens;
      seg_p1_ones <= dec_p1_ones;
      seg_p2_tens <= pat_p2_tens;
      seg_p2_ones <= dec_p2_ones;
    end
  end

endmodule
